// File: rtl/addsub_signed_pipe_if.sv
// addsub_signed_pipe_if: operand/result handshake bundle for addsub_signed_pipe.
// Ports: in_valid/in_ready with a, b, sub, sat; out_valid/out_ready with res, cout, overflow, zero, neg.
interface addsub_signed_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, sub, sat, out_ready,
        input  in_ready, out_valid, res, cout, overflow, zero, neg
    );

    modport slave (
        input  in_valid, a, b, sub, sat, out_ready,
        output in_ready, out_valid, res, cout, overflow, zero, neg
    );
endinterface

// File: rtl/addsub_signed_pipe.sv
// addsub_signed_pipe: pipelined signed add/sub, CHUNK bits of carry per stage, optional saturation.
// Ports: clk, rst (async active-high), io (slave side of addsub_signed_pipe_if).
module addsub_signed_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input logic                clk,
    input logic                rst,
    addsub_signed_pipe_if.slave io
);
    localparam int STAGES = WIDTH / CHUNK;
    // Register slots between stages; one dummy slot keeps arrays legal at STAGES == 1.
    localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             sat;
    } stage_t;

    stage_t           r   [NR];
    stage_t           cur [STAGES];
    stage_t           nxt [STAGES];
    stage_t           fin;
    logic [CHUNK:0]   t;
    logic             advance;
    logic             ovf_n;
    logic [WIDTH-1:0] res_n;

    logic             vld_q;
    logic [WIDTH-1:0] res_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    assign advance = !vld_q || io.out_ready;

    always_comb begin
        t      = '0;
        cur[0] = '0;
        cur[0].v   = io.in_valid;
        cur[0].a   = io.a;
        cur[0].b   = io.sub ? ~io.b : io.b;
        cur[0].c   = io.sub;
        cur[0].sat = io.sat;
        for (int k = 1; k < STAGES; k++) begin
            cur[k] = r[k-1];
        end
        // Each stage resolves its own chunk; other fields ride along.
        for (int k = 0; k < STAGES; k++) begin
            t = {1'b0, cur[k].a[k*CHUNK +: CHUNK]}
              + {1'b0, cur[k].b[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cur[k].c};
            nxt[k] = cur[k];
            nxt[k].s[k*CHUNK +: CHUNK] = t[CHUNK-1:0];
            nxt[k].c = t[CHUNK];
        end
        fin   = nxt[STAGES-1];
        ovf_n = (fin.a[WIDTH-1] == fin.b[WIDTH-1])
             && (fin.s[WIDTH-1] != fin.a[WIDTH-1]);
        res_n = fin.s;
        if (fin.sat && ovf_n) begin
            res_n = fin.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NR; k++) begin
                r[k] <= '0;
            end
            vld_q  <= 1'b0;
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                r[k] <= nxt[k];
            end
            vld_q  <= fin.v;
            res_q  <= res_n;
            cout_q <= fin.c;
            ovf_q  <= ovf_n;
            zero_q <= (res_n == '0);
            neg_q  <= res_n[WIDTH-1];
        end
    end

    assign io.in_ready  = advance;
    assign io.out_valid = vld_q;
    assign io.res       = res_q;
    assign io.cout      = cout_q;
    assign io.overflow  = ovf_q;
    assign io.zero      = zero_q;
    assign io.neg       = neg_q;
endmodule

// File: tb/tb_addsub_signed_pipe.sv
// tb_addsub_signed_pipe: directed and reference-model checks for addsub_signed_pipe.
// Instances: 8/4 (directed, stream, reset), 8/8 and 16/4 (random sweep).
module tb_addsub_signed_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    addsub_signed_pipe_if #(.WIDTH(8))  i0 ();
    addsub_signed_pipe_if #(.WIDTH(8))  i1 ();
    addsub_signed_pipe_if #(.WIDTH(16)) i2 ();

    addsub_signed_pipe #(.WIDTH(8),  .CHUNK(4)) u0 (.clk(clk), .rst(rst), .io(i0));
    addsub_signed_pipe #(.WIDTH(8),  .CHUNK(8)) u1 (.clk(clk), .rst(rst), .io(i1));
    addsub_signed_pipe #(.WIDTH(16), .CHUNK(4)) u2 (.clk(clk), .rst(rst), .io(i2));

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain signed integer arithmetic, result {res16, cout, ovf, zero, neg}.
    function automatic logic [19:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic sub, input logic sat);
        longint one = 1;
        longint ua, ub, sa, sb, r, m, hi, lo;
        logic [15:0] res;
        logic c, ov;
        ua = longint'(a);
        ub = longint'(b);
        m  = one << w;
        sa = a[w-1] ? ua - m : ua;
        sb = b[w-1] ? ub - m : ub;
        r  = sub ? sa - sb : sa + sb;
        hi = m / 2 - 1;
        lo = -(m / 2);
        ov = (r > hi) || (r < lo);
        c  = sub ? (ua >= ub) : (((ua + ub) >> w) != 0);
        if (sat && ov) r = (r > hi) ? hi : lo;
        res = 16'(r & (m - 1));
        return {res, c, ov, res == 16'h0, res[w-1]};
    endfunction

    function automatic logic [19:0] pack0();
        return {8'h00, i0.res, i0.cout, i0.overflow, i0.zero, i0.neg};
    endfunction
    function automatic logic [19:0] pack1();
        return {8'h00, i1.res, i1.cout, i1.overflow, i1.zero, i1.neg};
    endfunction
    function automatic logic [19:0] pack2();
        return {i2.res, i2.cout, i2.overflow, i2.zero, i2.neg};
    endfunction

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic sat, input logic [11:0] exp);
        i0.in_valid = 1'b1;
        i0.a = a;
        i0.b = b;
        i0.sub = sub;
        i0.sat = sat;
        @(posedge clk); #1;
        i0.in_valid = 1'b0;
        @(negedge clk);
        check({tag, " early"}, i0.out_valid, 0);
        @(negedge clk);
        check({tag, " valid"}, i0.out_valid, 1);
        check(tag, pack0(), {8'h00, exp});
        @(posedge clk); #1;
    endtask

    task automatic stream(input bit stall, output int first, output int last);
        logic [7:0]  sa [8];
        logic [7:0]  sb [8];
        logic [19:0] exp [8];
        logic [19:0] snap = '0;
        bit held = 1'b0;
        int sent = 0;
        int got  = 0;
        first = -1;
        last  = -1;
        for (int i = 0; i < 8; i++) begin
            sa[i]  = 8'(i * 37 + 5);
            sb[i]  = 8'(i * 91 + 200);
            exp[i] = model(8, {8'h0, sa[i]}, {8'h0, sb[i]}, i[0], i[1]);
        end
        for (int c = 0; c < 40 && got < 8; c++) begin
            i0.out_ready = !(stall && c >= 4 && c <= 6);
            i0.in_valid  = (sent < 8);
            if (sent < 8) begin
                i0.a   = sa[sent];
                i0.b   = sb[sent];
                i0.sub = sent[0];
                i0.sat = sent[1];
            end
            @(negedge clk);
            if (held) check("stall hold", {i0.out_valid, pack0()}, {1'b1, snap});
            if (i0.out_valid && !i0.out_ready) check("stall in_ready", i0.in_ready, 0);
            held = i0.out_valid && !i0.out_ready;
            snap = pack0();
            if (i0.in_valid && i0.in_ready) sent++;
            if (i0.out_valid && i0.out_ready) begin
                check($sformatf("stream res %0d", got), pack0(), exp[got]);
                if (first < 0) first = c;
                last = c;
                got++;
            end
            @(posedge clk); #1;
        end
        i0.in_valid  = 1'b0;
        i0.out_ready = 1'b1;
        check("stream count", got, 8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stream no extra", i0.out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int f, l, seen;
        logic [19:0] q1 [$];
        logic [19:0] q2 [$];
        i0.in_valid = 0; i0.a = 0; i0.b = 0; i0.sub = 0; i0.sat = 0; i0.out_ready = 1;
        i1.in_valid = 0; i1.a = 0; i1.b = 0; i1.sub = 0; i1.sat = 0; i1.out_ready = 1;
        i2.in_valid = 0; i2.a = 0; i2.b = 0; i2.sub = 0; i2.sat = 0; i2.out_ready = 1;

        #12;
        check("rst outputs", {i0.out_valid, pack0()}, 0);
        check("rst in_ready", i0.in_ready, 1);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        op8("7F+01 wrap", 8'h7F, 8'h01, 0, 0, {8'h80, 4'b0101});
        op8("7F+01 sat",  8'h7F, 8'h01, 0, 1, {8'h7F, 4'b0100});
        op8("80-01 wrap", 8'h80, 8'h01, 1, 0, {8'h7F, 4'b1100});
        op8("80-01 sat",  8'h80, 8'h01, 1, 1, {8'h80, 4'b1101});
        op8("05-05",      8'h05, 8'h05, 1, 0, {8'h00, 4'b1010});
        op8("0F+01",      8'h0F, 8'h01, 0, 0, {8'h10, 4'b0000});
        op8("FF+01",      8'hFF, 8'h01, 0, 0, {8'h00, 4'b1010});
        op8("00-01",      8'h00, 8'h01, 1, 0, {8'hFF, 4'b0001});

        stream(1'b1, f, l);
        stream(1'b0, f, l);
        check("tput latency", f, 2);
        check("tput span", l - f, 7);

        // Two operations in flight, then asynchronous reset between edges.
        i0.in_valid = 1; i0.a = 8'h11; i0.b = 8'h22; i0.sub = 0; i0.sat = 0;
        @(posedge clk); #1;
        i0.a = 8'h33; i0.b = 8'h44;
        @(posedge clk); #1;
        i0.in_valid = 0;
        check("pre-rst valid", i0.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst outputs", {i0.out_valid, pack0()}, 0);
        check("async rst in_ready", i0.in_ready, 1);
        @(posedge clk); #2 rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (i0.out_valid) seen++;
        end
        check("no stale result", seen, 0);
        check("post-rst in_ready", i0.in_ready, 1);
        @(posedge clk); #1;

        for (int c = 0; c < 140; c++) begin
            i1.in_valid  = (c < 120) && ($urandom_range(0, 3) != 0);
            i1.a = 8'($urandom);  i1.b = 8'($urandom);
            i1.sub = 1'($urandom); i1.sat = 1'($urandom);
            i1.out_ready = (c >= 120) || ($urandom_range(0, 3) != 0);
            i2.in_valid  = (c < 120) && ($urandom_range(0, 3) != 0);
            i2.a = 16'($urandom); i2.b = 16'($urandom);
            i2.sub = 1'($urandom); i2.sat = 1'($urandom);
            i2.out_ready = (c >= 120) || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (i1.in_valid && i1.in_ready)
                q1.push_back(model(8, {8'h0, i1.a}, {8'h0, i1.b}, i1.sub, i1.sat));
            if (i2.in_valid && i2.in_ready)
                q2.push_back(model(16, i2.a, i2.b, i2.sub, i2.sat));
            if (i1.out_valid && i1.out_ready) begin
                if (q1.size() == 0) check("sw8 spurious", 1, 0);
                else check("sw8 res", pack1(), q1.pop_front());
            end
            if (i2.out_valid && i2.out_ready) begin
                if (q2.size() == 0) check("sw16 spurious", 1, 0);
                else check("sw16 res", pack2(), q2.pop_front());
            end
            @(posedge clk); #1;
        end
        check("sw8 drained", q1.size(), 0);
        check("sw16 drained", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/addsub_signed_pipe.md
# addsub_signed_pipe

Pipelined, parametrised signed adder/subtractor with valid/ready handshake, optional saturation and a full flag set (carry, overflow, zero, negative). The carry chain is split into CHUNK-bit slices, one register stage per slice, so wide operands close timing at one result per cycle. It sits in the arithmetic datapath as the registered successor to the combinational add/sub unit, feeding downstream blocks that can apply backpressure.

## Interface
- WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (derived, not overridable).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set on a, b, sub, sat is valid.
- in_ready  output  1  block accepts the operand set this cycle.
- a  input  WIDTH  operand A, two's complement.
- b  input  WIDTH  operand B, two's complement.
- sub  input  1  1: res = a − b; 0: res = a + b.
- sat  input  1  1: clamp res on signed overflow; 0: wrap.
- out_valid  output  1  result fields valid.
- out_ready  input  1  downstream accepts the result this cycle.
- res  output  WIDTH  result, wrapped or saturated.
- cout  output  1  carry out of MSB (on subtract, 1 = no borrow, i.e. a ≥ b unsigned).
- overflow  output  1  signed overflow of the unsaturated sum.
- zero  output  1  res == 0 (after saturation).
- neg  output  1  res[WIDTH-1] (after saturation).

## Operation
- Arithmetic: b' = sub ? ~b : b; carry-in = sub. Raw sum {cout, raw} = a + b' + sub, over WIDTH+1 bits.
- overflow = (a[MSB] == b'[MSB]) && (raw[MSB] != a[MSB]).
- Saturation: if sat && overflow, res = a[MSB] ? {1, 0…0} (most negative) : {0, 1…1} (most positive); otherwise res = raw. cout and overflow always reflect the raw sum.
- Pipeline: stage k (0 … STAGES−1) adds chunk k of a and b' plus the registered carry from stage k−1. Not-yet-used upper operand chunks are delayed alongside; completed lower result chunks move forward with them. sub, sat and a[MSB]/b'[MSB] travel with the data.
- The final stage computes overflow, saturation, zero and neg, and registers all outputs.
- Each stage has a valid bit. Global advance = !out_valid || out_ready. All stages shift only when advance is 1; otherwise every stage, including outputs, holds.
- in_ready = advance, combinational from out_valid and out_ready. A transfer occurs on a rising edge with in_valid && in_ready; a bubble (valid 0) enters otherwise.
- Ordering is strictly FIFO. There is no drop, duplication or reordering.

## Timing
- Latency: an operand accepted at edge N appears with out_valid = 1 after edge N+STAGES−1 … precisely, out_valid rises on edge N+STAGES−1 when STAGES ≥ 1 counts the output register as the last stage. This means 1 cycle for CHUNK = WIDTH and 2 cycles for the default.
- Throughput: one result per cycle while out_ready is held high.
- Stall: while out_valid && !out_ready, in_ready = 0, and res/cout/overflow/zero/neg/out_valid hold stable bit-for-bit.
- Result consumed: on a cycle with out_valid && out_ready, a new result (or bubble) loads on the same edge, so there is no dead cycle.
- Reset: rst asynchronously clears every valid bit and every data register to 0. Outputs under reset: out_valid=0, res=0, cout=0, overflow=0, zero=0, neg=0; in_ready=1.
- Reset mid-operation: all in-flight operations are discarded, and no result for them is ever presented after rst deasserts.
- First possible transfer is on the first rising edge with rst low.

## Test plan
- WIDTH=8, CHUNK=4, add 0x7F+0x01: sat=0 → res 0x80, overflow 1, cout 0, neg 1, zero 0. sat=1 → res 0x7F, overflow 1, neg 0.
- Subtract 0x80−0x01: sat=0 → res 0x7F, overflow 1, cout 1. sat=1 → res 0x80, neg 1. Subtract 0x05−0x05 → res 0x00, zero 1, cout 1, overflow 0.
- Cross-chunk carry: 0x0F+0x01 → 0x10, cout 0. 0xFF+0x01 → 0x00, cout 1, zero 1, overflow 0. Subtract 0x00−0x01 → 0xFF, cout 0, neg 1.
- Streaming and backpressure: 8 back-to-back operands with out_ready low for 3 cycles mid-stream → in_ready low during the stall, outputs held constant, all 8 results in order, exactly once. With out_ready high, 1 result per cycle at 2-cycle latency.
- Reset mid-stream: assert rst asynchronously with 2 operations in flight → out_valid drops to 0 and all outputs go to 0 without a clock edge. After release, no stale result appears and in_ready=1.
- Parameter sweep: CHUNK=WIDTH=8 (latency 1) and WIDTH=16, CHUNK=4 (latency 4) against a reference model on random operands and random sub, sat and out_ready → bit-exact match of all fields.
